// File: rtl/mips_cpu_datapath_core.sv
// Multi-cycle MIPS32 execution datapath: register file, ALU and multiplier.
// Define MIPS_CPU_MULT_EN to build the 32x32->64 multiplier; otherwise mult_out is 0.
module mips_cpu_datapath_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    output logic [31:0] register_v0,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [4:0]  alu_sa,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    input  logic        mult_sign,
    output logic [63:0] mult_out
);

    logic [31:0] regs_q [32];
    logic        wr_en_d;

    assign wr_en_d = reg_write && (wr_addr != 5'd0);

    // Register file storage: async clear, one write port, r0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a   = (rd_addr_a == 5'd0) ? 32'd0 : regs_q[rd_addr_a];
    assign rd_data_b   = (rd_addr_b == 5'd0) ? 32'd0 : regs_q[rd_addr_b];
    assign register_v0 = regs_q[2];

    // ALU: opcode-selected combinational result, unused opcodes give 0
    always_comb begin
        alu_result = '0;
        case (alu_op)
            5'd0:    alu_result = alu_a & alu_b;
            5'd1:    alu_result = alu_a | alu_b;
            5'd2:    alu_result = alu_a + alu_b;
            5'd3:    alu_result = alu_a - alu_b;
            5'd4:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            5'd5:    alu_result = alu_a ^ alu_b;
            5'd6:    alu_result = alu_b << alu_sa;
            5'd7:    alu_result = alu_b >> alu_sa;
            5'd8:    alu_result = $signed(alu_b) >>> alu_sa;
            5'd9:    alu_result = alu_b << alu_a[4:0];
            5'd10:   alu_result = alu_b >> alu_a[4:0];
            5'd11:   alu_result = $signed(alu_b) >>> alu_a[4:0];
            5'd12:   alu_result = {alu_b[15:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

`ifdef MIPS_CPU_MULT_EN
    logic [63:0] mul_a_d;
    logic [63:0] mul_b_d;

    // Multiplier: extend operands to 64 bits (sign or zero), keep low 64 of product
    always_comb begin
        mul_a_d  = {{32{mult_sign & alu_a[31]}}, alu_a};
        mul_b_d  = {{32{mult_sign & alu_b[31]}}, alu_b};
        mult_out = mul_a_d * mul_b_d;
    end
`else
    logic unused_mult_sign;

    assign unused_mult_sign = mult_sign;
    assign mult_out         = 64'h0;
`endif

endmodule

// File: tb/tb_mips_cpu_datapath_core.sv
// Testbench for mips_cpu_datapath_core: random stimulus vs behavioural model,
// plus directed literal checks.
module tb_mips_cpu_datapath_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] register_v0;
    logic [4:0]  alu_op = '0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [4:0]  alu_sa = '0;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        mult_sign = 1'b0;
    logic [63:0] mult_out;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mreg [32];

    mips_cpu_datapath_core dut (
        .clk(clk), .rst(rst), .reg_write(reg_write),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .register_v0(register_v0),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .mult_sign(mult_sign), .mult_out(mult_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sra(input logic [31:0] v, input int sh);
        logic [63:0] t;
        t = {{32{v[31]}}, v} >> sh;
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input int sa);
        int av;
        av = int'(a % 32);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a + b;
            3: return a - b;
            4: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return b << sa;
            7: return b >> sa;
            8: return sra(b, sa);
            9: return b << av;
            10: return b >> av;
            11: return sra(b, av);
            12: return (b & 32'h0000FFFF) * 32'h00010000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] m_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
`ifdef MIPS_CPU_MULT_EN
        longint pa, pb;
        if (s) begin
            pa = longint'(int'(a));
            pb = longint'(int'(b));
            return 64'(pa * pb);
        end
        return {32'd0, a} * {32'd0, b};
`else
        return (s ^ s) ? {a, b} : 64'h0;
`endif
    endfunction

    initial for (int i = 0; i < 32; i++) mreg[i] = '0;

    always @(negedge rst) for (int i = 0; i < 32; i++) mreg[i] = '0;

    always @(posedge clk)
        if (rst && reg_write && wr_addr != 5'd0) mreg[wr_addr] = wr_data;

    // Compare process: every negedge, all outputs against the model
    always @(negedge clk) begin
        logic [31:0] er;
        chk("rd_a", {32'd0, rd_data_a}, {32'd0, mreg[rd_addr_a]});
        chk("rd_b", {32'd0, rd_data_b}, {32'd0, mreg[rd_addr_b]});
        chk("v0", {32'd0, register_v0}, {32'd0, mreg[2]});
        er = m_alu(int'(alu_op), alu_a, alu_b, int'(alu_sa));
        chk("alu", {32'd0, alu_result}, {32'd0, er});
        chk("zero", {63'd0, alu_zero}, {63'd0, er == 32'd0});
        chk("mul", mult_out, m_mul(mult_sign, alu_a, alu_b));
    end

    task automatic alu_chk(input string nm, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sa, input logic [31:0] exp);
        alu_op = op; alu_a = a; alu_b = b; alu_sa = sa;
        #1;
        chk(nm, {32'd0, alu_result}, {32'd0, exp});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'hFFFFFFFF;
            1: return 32'h80000000;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset held: writes ignored, reads zero
        reg_write = 1'b1; wr_addr = 5'd2; wr_data = 32'hAAAA5555;
        rd_addr_a = 5'd2;
        @(posedge clk); #1;
        chk("rst_rd_a", {32'd0, rd_data_a}, 64'd0);
        chk("rst_v0", {32'd0, register_v0}, 64'd0);
        rst = 1'b1;
        wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("v0_write", {32'd0, register_v0}, 64'hDEADBEEF);
        wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr_a = 5'd0;
        @(posedge clk); #1;
        chk("r0_zero", {32'd0, rd_data_a}, 64'd0);
        wr_addr = 5'd5; wr_data = 32'h1;
        @(posedge clk); #1;
        wr_data = 32'h2; rd_addr_a = 5'd5;
        #1;
        chk("rdw_old", {32'd0, rd_data_a}, 64'h1);
        @(posedge clk); #1;
        reg_write = 1'b0;
        chk("rdw_new", {32'd0, rd_data_a}, 64'h2);
        #1 rst = 1'b0;
        #1 chk("rst_mid", {32'd0, rd_data_a}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        alu_chk("add_wrap", 5'd2, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0);
        chk("add_zero", {63'd0, alu_zero}, 64'd1);
        alu_chk("sub_wrap", 5'd3, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF);
        alu_chk("slt_neg", 5'd4, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
        alu_chk("slt_pos", 5'd4, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
        alu_chk("sll", 5'd6, 32'd0, 32'h80000000, 5'd4, 32'd0);
        alu_chk("srl", 5'd7, 32'd0, 32'h80000000, 5'd4, 32'h08000000);
        alu_chk("sra", 5'd8, 32'd0, 32'h80000000, 5'd4, 32'hF8000000);
        alu_chk("srav", 5'd11, 32'h24, 32'h80000000, 5'd0, 32'hF8000000);
        alu_chk("lui", 5'd12, 32'd0, 32'hFFFF8001, 5'd0, 32'h80010000);
        alu_chk("and", 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000);
        alu_chk("or", 5'd1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0);
        alu_chk("xor", 5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0);
        alu_chk("undef", 5'd20, 32'h1234, 32'h5678, 5'd3, 32'd0);
        chk("undef_zero", {63'd0, alu_zero}, 64'd1);

        alu_a = 32'hFFFFFFFF; alu_b = 32'd2; mult_sign = 1'b1;
        #1;
`ifdef MIPS_CPU_MULT_EN
        chk("mul_s", mult_out, 64'hFFFFFFFF_FFFFFFFE);
`else
        chk("mul_s", mult_out, 64'h0);
`endif
        mult_sign = 1'b0;
        #1;
`ifdef MIPS_CPU_MULT_EN
        chk("mul_u", mult_out, 64'h00000001_FFFFFFFE);
`else
        chk("mul_u", mult_out, 64'h0);
`endif

        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 49) != 0);
            reg_write = $urandom_range(0, 2) != 0;
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = pick();
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 31));
            alu_op    = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) alu_op = 5'($urandom_range(13, 31));
            alu_a     = pick();
            alu_b     = pick();
            alu_sa    = 5'($urandom);
            mult_sign = 1'($urandom);
        end
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
